// File: rtl/uart_loader.sv
// UART program loader: receives a framed image on uart_rx and writes it word-by-word into memory,
// holding the core in reset until a load completes with a good checksum.
//  state | meaning
//  IDLE  | after reset, waiting for 0xA5 magic
//  LEN0  | expecting N[7:0]
//  LEN1  | expecting N[15:8]
//  DATA  | collecting 4*N data bytes, one write per 4 bytes
//  CSUM  | expecting XOR of all data bytes
//  DONE  | load good, core released, waiting for next 0xA5
//  ERR   | load aborted, core held, waiting for next 0xA5
module uart_loader #(
    parameter int          CLK_HZ       = 12_000_000,
    parameter int          BAUD         = 115_200,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          TIMEOUT_BITS = 256,
    parameter bit          BOOT_WAIT    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        mem_wen,
    output logic [31:0] mem_wa,
    output logic [31:0] mem_wd,
    output logic [2:0]  mem_funct3,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        err
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int BIT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W         = $clog2(TO_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

    logic             rx_s1, rx_s2, rx_d;
    logic             rx_active;
    logic [BIT_W-1:0] rx_cnt;
    logic [3:0]       rx_idx;
    logic [7:0]       rx_byte;
    logic             byte_valid, frame_err;

    // rx_idx: 0 = start bit, 1..8 = data bits, 9 = stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_d       <= 1'b1;
            rx_active  <= 1'b0;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= uart_rx;
            rx_s2      <= rx_s1;
            rx_d       <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!rx_active) begin
                if (rx_d && !rx_s2) begin
                    rx_active <= 1'b1;
                    rx_idx    <= 4'd0;
                    rx_cnt    <= BIT_W'(CLKS_PER_BIT / 2 - 1);
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - BIT_W'(1);
            end else begin
                rx_cnt <= BIT_W'(CLKS_PER_BIT - 1);
                rx_idx <= rx_idx + 4'd1;
                if (rx_idx == 4'd0) begin
                    if (rx_s2) rx_active <= 1'b0;
                end else if (rx_idx <= 4'd8) begin
                    rx_byte <= {rx_s2, rx_byte[7:1]};
                end else begin
                    rx_active  <= 1'b0;
                    byte_valid <= rx_s2;
                    frame_err  <= !rx_s2;
                end
            end
        end
    end

    state_t          state, next_state;
    logic [7:0]      len_lo, csum;
    logic [15:0]     words_left;
    logic [1:0]      byte_idx;
    logic [23:0]     word_sh;
    logic [31:0]     addr;
    logic [TO_W-1:0] to_cnt;
    logic            in_frame, start_frame, store_word;

    assign mem_funct3 = 3'b010;
    assign in_frame   = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);

    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        store_word  = 1'b0;
        case (state)
            LEN0: if (byte_valid) next_state = LEN1;
            LEN1: if (byte_valid) next_state = ({rx_byte, len_lo} == 16'd0) ? CSUM : DATA;
            DATA: if (byte_valid && byte_idx == 2'd3) begin
                store_word = 1'b1;
                if (words_left == 16'd1) next_state = CSUM;
            end
            CSUM: if (byte_valid) next_state = (rx_byte == csum) ? DONE : ERR;
            default: if (byte_valid && rx_byte == 8'hA5) begin
                next_state  = LEN0;
                start_frame = 1'b1;
            end
        endcase
        if (in_frame && (frame_err || to_cnt == '0)) next_state = ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_wen    <= 1'b0;
            mem_wa     <= BASE_ADDR;
            mem_wd     <= '0;
            cpu_rst_n  <= !BOOT_WAIT;
            done       <= 1'b0;
            err        <= 1'b0;
            len_lo     <= '0;
            csum       <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            word_sh    <= '0;
            addr       <= BASE_ADDR;
            to_cnt     <= '0;
        end else begin
            state   <= next_state;
            mem_wen <= store_word;
            if (in_frame) to_cnt <= byte_valid ? TO_W'(TO_CYCLES - 1) : to_cnt - TO_W'(1);
            if (start_frame) begin
                to_cnt    <= TO_W'(TO_CYCLES - 1);
                cpu_rst_n <= 1'b0;
                done      <= 1'b0;
                err       <= 1'b0;
                addr      <= BASE_ADDR;
                csum      <= '0;
                byte_idx  <= '0;
            end
            if (byte_valid) begin
                if (state == LEN0) len_lo <= rx_byte;
                if (state == LEN1) words_left <= {rx_byte, len_lo};
                if (state == DATA) begin
                    csum     <= csum ^ rx_byte;
                    byte_idx <= byte_idx + 2'd1;
                    word_sh  <= {rx_byte, word_sh[23:8]};
                end
            end
            if (store_word) begin
                mem_wa     <= addr;
                mem_wd     <= {rx_byte, word_sh};
                addr       <= addr + 32'd4;
                words_left <= words_left - 16'd1;
            end
            if (next_state == DONE && state != DONE) begin
                done      <= 1'b1;
                cpu_rst_n <= 1'b1;
            end
            if (next_state == ERR && state != ERR) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: serial frames in, memory writes checked against a scoreboard queue.
module tb_uart_loader;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 125_000;
    localparam int CPB    = CLK_HZ / BAUD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        mem_wen;
    logic [31:0] mem_wa, mem_wd;
    logic [2:0]  mem_funct3;
    logic        cpu_rst_n, done, err;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          w0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_w;
    logic [7:0]  tx_q[$];

    uart_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .BASE_ADDR(32'h0), .TIMEOUT_BITS(256), .BOOT_WAIT(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .mem_wen(mem_wen), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_funct3(mem_funct3),
        .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected {addr,data}.
    always @(negedge clk) begin
        if (rst_n && mem_wen) begin
            wr_cnt++;
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                chk("wr_addr", mem_wa, exp_w[63:32]);
                chk("wr_data", mem_wd, exp_w[31:0]);
                chk("wr_funct3", 32'(mem_funct3), 32'd2);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_q();
        while (tx_q.size() != 0) send_byte(tx_q.pop_front());
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_wen"}, 32'(mem_wen), 32'd0);
        chk({pfx, "_wa"}, mem_wa, 32'h0);
        chk({pfx, "_wd"}, mem_wd, 32'h0);
        chk({pfx, "_funct3"}, 32'(mem_funct3), 32'd2);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_err"}, 32'(err), 32'd0);
        chk({pfx, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    endtask

    task automatic check_status(input string pfx, input logic d, input logic e, input logic c);
        chk({pfx, "_done"}, 32'(done), 32'(d));
        chk({pfx, "_err"}, 32'(err), 32'(e));
        chk({pfx, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(c));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // boot wait: core held, nothing written while the line is idle
        repeat (10000) @(negedge clk);
        chk("boot_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("boot_writes", 32'(wr_cnt), 32'd0);
        send_byte(8'h55);
        check_status("idle_stray", 1'b0, 1'b0, 1'b0);

        // good two-word image
        w0 = wr_cnt;
        exp_q.push_back({32'h0, 32'h0000_0013});
        exp_q.push_back({32'h4, 32'h0000_006F});
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
        send_q();
        check_status("good", 1'b1, 1'b0, 1'b1);
        chk("good_writes", 32'(wr_cnt - w0), 32'd2);
        chk("good_wa_hold", mem_wa, 32'h4);
        chk("good_wd_hold", mem_wd, 32'h6F);

        // bad checksum: writes still happen
        w0 = wr_cnt;
        exp_q.push_back({32'h0, 32'h0000_0013});
        exp_q.push_back({32'h4, 32'h0000_006F});
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00};
        send_q();
        check_status("badcsum", 1'b0, 1'b1, 1'b0);
        chk("badcsum_writes", 32'(wr_cnt - w0), 32'd2);

        exp_q.push_back({32'h0, 32'h0000_0013});
        exp_q.push_back({32'h4, 32'h0000_006F});
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
        send_q();
        check_status("reload", 1'b1, 1'b0, 1'b1);

        // inter-byte timeout after a partial word
        w0 = wr_cnt;
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'hAA};
        send_q();
        repeat (250 * CPB) @(negedge clk);
        check_status("to_early", 1'b0, 1'b0, 1'b0);
        repeat (10 * CPB) @(negedge clk);
        check_status("to_late", 1'b0, 1'b1, 1'b0);
        chk("to_writes", 32'(wr_cnt - w0), 32'd0);
        send_byte(8'h55);
        check_status("err_stray", 1'b0, 1'b1, 1'b0);

        // zero-length images
        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_q();
        check_status("zero_good", 1'b1, 1'b0, 1'b1);
        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h01};
        send_q();
        check_status("zero_bad", 1'b0, 1'b1, 1'b0);
        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_q();
        check_status("zero_good2", 1'b1, 1'b0, 1'b1);

        // framing error inside DATA
        tx_q = '{8'hA5, 8'h01, 8'h00};
        send_q();
        check_status("frm_hdr", 1'b0, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0);
        check_status("frm_err", 1'b0, 1'b1, 1'b0);
        chk("zero_frm_writes", 32'(wr_cnt - w0), 32'd0);

        // reset mid-word, then a fresh load from BASE_ADDR
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD};
        send_q();
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        w0 = wr_cnt;
        exp_q.push_back({32'h0, 32'h1234_5678});
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_q();
        check_status("fresh", 1'b1, 1'b0, 1'b1);
        chk("fresh_writes", 32'(wr_cnt - w0), 32'd1);
        chk("fresh_wa", mem_wa, 32'h0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
